fetch_prefetch_unit: RTL and testbench

//  Instruction-fetch stage upstream of the 5-stage core. Owns the fetch PC and issues
//  in-order word reads to instruction memory over a valid/ready request channel.

---
 rtl/fetch_prefetch_unit.sv | 81 ++++++++
 tb/tb_fetch_prefetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: in-order instruction prefetch with credit-limited requests,
// a DEPTH-entry instruction FIFO and redirect flush of stale in-flight responses.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = AW + 2;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [OW-1:0] outstanding, outstanding_n, discard, discard_n;
  logic [PW-1:0] wptr, rptr, pq_w, pq_r, occ;
  logic [31:0] data_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic acc, rsp, push, pop;
  assign occ            = wptr - rptr;
  assign instr_valid    = wptr != rptr;
  assign instr          = instr_valid ? data_q[rptr[AW-1:0]] : 32'h0000_0013;
  assign instr_pc       = instr_valid ? pc_q[rptr[AW-1:0]] : 32'h0;
  // Credit rule: buffered plus in-flight never exceeds DEPTH, so the FIFO cannot overflow.
  assign imem_req_valid = (state == FETCH) && (CW'(occ) + CW'(outstanding) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign acc            = imem_req_valid && imem_req_ready;
  assign rsp            = imem_resp_valid && (outstanding != '0);
  assign pop            = instr_valid && instr_ready;
  assign push           = rsp && (state == FETCH) && (discard == '0) && !redirect_valid;
  always_comb begin
    outstanding_n = outstanding + OW'(acc) - OW'(rsp);
    discard_n     = (redirect_valid && state != FLUSH) ? outstanding_n
                                                       : discard - OW'(rsp && discard != '0);
    fetch_pc_n    = redirect_valid ? (redirect_pc & ~32'd3) : fetch_pc + (acc ? 32'd4 : 32'd0);
    state_n       = (discard_n != '0) ? FLUSH : FETCH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      wptr        <= '0;
      rptr        <= '0;
      pq_w        <= '0;
      pq_r        <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      pq_w        <= pq_w + PW'(acc);
      pq_r        <= pq_r + PW'(rsp);
      wptr        <= redirect_valid ? '0 : wptr + PW'(push);
      rptr        <= redirect_valid ? '0 : rptr + PW'(pop);
    end
  end
  // Accepted addresses queue up alongside the requests so each response finds its PC.
  always_ff @(posedge clk) begin
    if (acc) addr_q[pq_w[AW-1:0]] <= fetch_pc;
    if (push) begin
      data_q[wptr[AW-1:0]] <= imem_resp_data;
      pc_q[wptr[AW-1:0]]   <= addr_q[pq_r[AW-1:0]];
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: randomized imem/IF-ID environment with an epoch-tagged
// reference model and a scoreboard of instructions expected at the DUT output.
module tb_fetch_prefetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;
  logic clk, rst_n, redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic instr_valid, instr_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_resp_data, instr, instr_pc;
  typedef struct { logic [31:0] addr; int ep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  req_t infl[$];
  ent_t sb[$];
  int ep, n_checks, n_fail;
  logic idle;
  logic [31:0] next_addr, s_addr, s_rpc;
  logic s_acc, s_rsp, s_pop, s_redir;
  int p_ready, p_resp, p_instr, p_redir, p_bad;

  fetch_prefetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic int stale();
    int n = 0;
    foreach (infl[i]) if (infl[i].ep != ep) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 0);
  endtask

  task automatic model_reset();
    infl.delete();
    sb.delete();
    ep = 0;
    idle = 1;
    next_addr = RESET_PC;
    {s_acc, s_rsp, s_pop, s_redir} = '0;
    s_addr = 0;
    s_rpc = 0;
  endtask

  // Monitor: compare DUT outputs against the scoreboard head and the credit rule, then snapshot handshakes.
  always @(negedge clk) if (rst_n) begin
    check("req_valid", 32'(imem_req_valid),
          32'(!idle && stale() == 0 && sb.size() + infl.size() < DEPTH));
    check("req_addr", imem_req_addr, next_addr);
    check("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
    check("instr", instr, sb.size() != 0 ? sb[0].data : 32'h0000_0013);
    check("instr_pc", instr_pc, sb.size() != 0 ? sb[0].pc : 32'h0);
    s_acc   = imem_req_valid && imem_req_ready;
    s_addr  = imem_req_addr;
    s_rsp   = imem_resp_valid && infl.size() > 0;
    s_pop   = sb.size() != 0 && instr_ready;
    s_redir = redirect_valid;
    s_rpc   = redirect_pc;
  end

  // Reference model: requests carry the epoch they were accepted in; a redirect opens a new epoch.
  always @(posedge clk) if (rst_n) begin
    int old_ep;
    req_t e;
    old_ep = ep;
    if (s_pop) void'(sb.pop_front());
    if (s_redir) begin
      ep++;
      sb.delete();
    end
    if (s_rsp) begin
      e = infl.pop_front();
      if (e.ep == ep) sb.push_back('{e.addr, mem(e.addr)});
    end
    if (s_acc) infl.push_back('{s_addr, old_ep});
    next_addr = s_redir ? {s_rpc[31:2], 2'b00} : next_addr + (s_acc ? 32'd4 : 32'd0);
    idle = 0;
  end

  task automatic knobs(input int r, input int rs, input int ir, input int rd);
    p_ready = r; p_resp = rs; p_instr = ir; p_redir = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    imem_req_ready = $urandom_range(99) < p_ready;
    if (infl.size() > 0) begin
      imem_resp_valid = $urandom_range(99) < p_resp;
      imem_resp_data  = mem(infl[0].addr);
    end else begin
      imem_resp_valid = $urandom_range(99) < p_bad;
      imem_resp_data  = $urandom;
    end
    instr_ready    = $urandom_range(99) < p_instr;
    redirect_valid = $urandom_range(99) < p_redir;
    redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
  endtask

  task automatic force_redirect(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
  endtask

  initial begin
    rst_n = 0;
    {redirect_valid, imem_req_ready, imem_resp_valid, instr_ready} = '0;
    redirect_pc = 0;
    imem_resp_data = 0;
    n_checks = 0;
    n_fail = 0;
    p_bad = 0;
    model_reset();
    #2 check_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    // sequential fetch with everything ready
    knobs(100, 100, 100, 0);
    repeat (20) step();
    // consumer stalled: credit limit caps requests at DEPTH
    knobs(100, 100, 0, 0);
    repeat (12) step();
    knobs(100, 100, 100, 0);
    repeat (10) step();
    // redirect with two requests in flight
    knobs(100, 0, 100, 0);
    for (int i = 0; i < 20 && infl.size() != 2; i++) step();
    check("setup_two_inflight", infl.size(), 2);
    imem_req_ready = 0;
    imem_resp_valid = 0;
    force_redirect(32'h100);
    knobs(100, 100, 100, 0);
    repeat (15) step();
    // redirect coinciding with accept and response
    repeat (3) step();
    force_redirect(32'h200);
    repeat (15) step();
    // imem stall with a redirect mid-stall
    knobs(0, 100, 100, 0);
    repeat (3) step();
    force_redirect(32'h303);
    repeat (3) step();
    knobs(100, 100, 100, 0);
    repeat (10) step();
    // asynchronous reset with buffered instructions
    knobs(100, 100, 0, 0);
    for (int i = 0; i < 50 && sb.size() < 3; i++) step();
    check("setup_three_buffered", 32'(sb.size() >= 3), 1);
    #3 rst_n = 0;
    #1 check_reset();
    model_reset();
    {redirect_valid, imem_req_ready, imem_resp_valid, instr_ready} = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    knobs(100, 100, 100, 0);
    repeat (20) step();
    // randomized traffic including protocol-violating responses
    knobs(70, 50, 60, 4);
    p_bad = 10;
    repeat (3000) step();
    p_bad = 0;
    knobs(100, 100, 100, 0);
    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
